cpu_control_fsm: RTL and testbench
==================================

# cpu_control_fsm

Multi-cycle fetch/decode/execute controller for the 8-bit CPU. It fetches instruction bytes from instruction memory over a request/ready handshake, decodes them, and drives the register-file read indices, the ALU opcode and the register-file write port. It also owns the program counter and the zero flag. It sits directly upstream of the 4x8 register file and ALU, and consumes the ALU result for writeback.

## Interface
Parameters:
- RESET_PC, 8'h00, PC value loaded on reset.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request; held high until accepted.
- imem_addr  out  8  fetch address (current PC).
- imem_ready  in  1  memory has valid imem_data this cycle; accepts the request.
- imem_data  in  8  fetched byte.
- rf_src1  out  2  register-file src1 index (rd field).
- rf_src2  out  2  register-file src2 index (rs field).
- rf_dest  out  2  register-file write index (rd field).
- rf_we  out  1  register-file write enable.
- rf_write_data  out  8  writeback data: alu_result, or the immediate for LDI.
- alu_op  out  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 PASS_B.
- alu_result  in  8  combinational ALU result of src1_data op src2_data.
- pc  out  8  program counter.
- zero_flag  out  1  set when the last ALU operation gave a zero result.
- halted  out  1  high in HALT.
- illegal  out  1  one-cycle pulse on an undefined opcode.

## Operation
- Instruction byte: opcode [7:4], rd [3:2], rs [1:0].
- Opcodes:
  - 0 NOP.
  - 1–5 ADD/SUB/AND/OR/XOR: rd <= rd op rs; zero flag updated.
  - 6 MOV: rd <= rs through PASS_B; zero flag unchanged.
  - 7 LDI: rd <= next byte.
  - 8 JMP: pc <= next byte.
  - 9 JZ: pc <= next byte if zero_flag, else fall through.
  - F HLT.
  - A–E illegal: pulse `illegal`, then behave as NOP.
- States: FETCH, DECODE, FETCH_OP, EXECUTE, HALT.
  - FETCH: imem_req=1, imem_addr=pc. On imem_ready, latch the byte into the IR, pc <= pc+1, go to DECODE.
  - DECODE: rf_src1/rf_src2/rf_dest/alu_op driven from the IR.
    - Opcodes 7, 8, 9 go to FETCH_OP.
    - F goes to HALT.
    - All others go to EXECUTE.
  - FETCH_OP: same handshake as FETCH. Latch the byte into the OPR, pc <= pc+1, go to EXECUTE.
  - EXECUTE:
    - ALU ops and MOV: rf_we=1, rf_write_data=alu_result.
    - LDI: rf_we=1, rf_write_data=OPR.
    - JMP, and JZ with zero_flag=1: pc <= OPR.
    - NOP/illegal: no write.
    - Always returns to FETCH.
  - HALT: terminal, all enables low; only reset exits.
- Zero flag: in EXECUTE of opcodes 1–5, zero_flag <= (alu_result == 8'h00).
- PC arithmetic is 8-bit modulo. 0xFF+1 wraps to 0x00, including a second-byte fetch at 0xFF.
- rf_src1/rf_src2/rf_dest/alu_op derive from the IR, which is registered, so they are stable from DECODE through EXECUTE.

## Timing
- Reset (asynchronous) gives:
  - state=FETCH, pc=RESET_PC, IR=OPR=0, zero_flag=0.
  - All outputs 0, except imem_addr=RESET_PC.
  - imem_req rises in the first clock cycle after reset deasserts.
- Handshake:
  - imem_req and imem_addr stay stable until the cycle in which imem_ready=1.
  - imem_data is sampled in that same cycle.
  - imem_ready while imem_req=0 is ignored.
- Latency with zero-wait memory (imem_ready high in the first request cycle):
  - ALU/MOV/NOP: 3 cycles (FETCH, DECODE, EXECUTE).
  - LDI/JMP/JZ: 4 cycles.
  - Each wait cycle adds 1.
- rf_we is high for exactly one cycle per writing instruction; the register file captures on that edge.
- illegal pulses in the EXECUTE cycle of an A–E opcode.
- Reset mid-handshake or mid-EXECUTE aborts the operation; no partial register write occurs after reset asserts.

## Structure
- Add to defines.vh:
  - Opcode constants.
  - ALU op codes.
  - 3-bit state encoding.
- Sub-module: instr_decoder, combinational, IR to {alu_op, needs_operand, writes_rf, updates_zero, is_jump, is_jz, is_halt, is_illegal}.
- The FSM, PC, IR/OPR and zero flag stay in cpu_control_fsm.

## Test plan
- Reset then zero-wait memory of 0x75,0x3C (LDI r1,0x3C) → imem_addr 0x00, then 0x01; one rf_we pulse with rf_dest=1, rf_write_data=0x3C; pc=0x02.
- ADD r1,r2 (0x16) with alu_result=0x00 → rf_we with data 0x00, zero_flag=1. Following JZ 0x40 (0x90,0x40) → pc=0x40. Repeat with zero_flag=0 → pc falls through.
- imem_ready held low for 5 cycles during FETCH → imem_req/imem_addr stable; no state advance, no pc change.
- pc=0xFF fetching JMP (0x80, second byte from 0x00) → second fetch at imem_addr 0x00; pc=OPR afterwards.
- Opcode 0xB0 → illegal high for one cycle, no rf_we. HLT (0xF0) → halted=1, imem_req=0 forever.
- Assert reset during EXECUTE of ADD → rf_we=0 immediately, pc=RESET_PC, zero_flag=0, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/cpu_control_fsm_pkg.sv
// Shared encodings for the 8-bit CPU control path: opcodes, ALU operations,
// controller states and the decoded-instruction bundle.
package cpu_control_fsm_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_MOV = 4'h6;
    localparam logic [3:0] OP_LDI = 4'h7;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_JZ  = 4'h9;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        ALU_ADD    = 3'd0,
        ALU_SUB    = 3'd1,
        ALU_AND    = 3'd2,
        ALU_OR     = 3'd3,
        ALU_XOR    = 3'd4,
        ALU_PASS_B = 3'd5
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_FETCH    = 3'd0,
        ST_DECODE   = 3'd1,
        ST_FETCH_OP = 3'd2,
        ST_EXECUTE  = 3'd3,
        ST_HALT     = 3'd4
    } state_e;

    typedef struct packed {
        alu_op_e alu_op;
        logic    needs_operand;
        logic    writes_rf;
        logic    updates_zero;
        logic    is_jump;
        logic    is_jz;
        logic    is_halt;
        logic    is_illegal;
    } decode_t;

    // Program counter advances modulo 256.
    function automatic logic [7:0] pc_inc(input logic [7:0] p);
        return p + 8'd1;
    endfunction

endpackage

// File: rtl/cpu_control_fsm_instr_decoder.sv
// Combinational instruction decoder: maps the instruction register to the
// control attributes the controller needs.
module instr_decoder
    import cpu_control_fsm_pkg::*;
(
    input  logic [7:0] ir,
    output decode_t    dec
);

    // Decode the opcode nibble; anything undefined is flagged illegal and
    // otherwise behaves as a NOP.
    always_comb begin
        dec        = '0;
        dec.alu_op = ALU_ADD;
        case (ir[7:4])
            OP_NOP: begin
                dec.alu_op = ALU_ADD;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                // ALU opcodes are laid out one below the instruction opcodes
                dec.alu_op       = alu_op_e'(ir[6:4] - 3'd1);
                dec.writes_rf    = 1'b1;
                dec.updates_zero = 1'b1;
            end
            OP_MOV: begin
                dec.alu_op    = ALU_PASS_B;
                dec.writes_rf = 1'b1;
            end
            OP_LDI: begin
                dec.needs_operand = 1'b1;
                dec.writes_rf     = 1'b1;
            end
            OP_JMP: begin
                dec.needs_operand = 1'b1;
                dec.is_jump       = 1'b1;
            end
            OP_JZ: begin
                dec.needs_operand = 1'b1;
                dec.is_jz         = 1'b1;
            end
            OP_HLT: begin
                dec.is_halt = 1'b1;
            end
            default: begin
                dec.is_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle fetch/decode/execute controller for the 8-bit CPU. Owns the
// program counter, instruction/operand registers and the zero flag.
module cpu_control_fsm
    import cpu_control_fsm_pkg::*;
#(
    parameter logic [7:0] RESET_PC = 8'h00
)
(
    input  logic       clk,
    input  logic       reset,
    output logic       imem_req,
    output logic [7:0] imem_addr,
    input  logic       imem_ready,
    input  logic [7:0] imem_data,
    output logic [1:0] rf_src1,
    output logic [1:0] rf_src2,
    output logic [1:0] rf_dest,
    output logic       rf_we,
    output logic [7:0] rf_write_data,
    output logic [2:0] alu_op,
    input  logic [7:0] alu_result,
    output logic [7:0] pc,
    output logic       zero_flag,
    output logic       halted,
    output logic       illegal
);

    state_e     state;
    logic [7:0] ir;
    logic [7:0] opr;
    decode_t    dec;

    instr_decoder u_instr_decoder (
        .ir  (ir),
        .dec (dec)
    );

    // Register-file indices and ALU op come straight from the registered IR,
    // so they hold steady from DECODE through EXECUTE.
    assign rf_src1   = ir[3:2];
    assign rf_src2   = ir[1:0];
    assign rf_dest   = ir[3:2];
    assign alu_op    = dec.alu_op;
    assign imem_addr = pc;

    // Writeback mux: LDI writes the operand byte, everything else the ALU result.
    always_comb begin
        rf_write_data = 8'h00;
        if (rf_we) begin
            if (dec.needs_operand) begin
                rf_write_data = opr;
            end else begin
                rf_write_data = alu_result;
            end
        end
    end

    // Controller state machine with registered handshake and strobe outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_FETCH;
            pc        <= RESET_PC;
            ir        <= 8'h00;
            opr       <= 8'h00;
            zero_flag <= 1'b0;
            imem_req  <= 1'b0;
            rf_we     <= 1'b0;
            halted    <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    // The request is raised one cycle after reset; ready is
                    // only honoured while the request is up.
                    if (imem_req && imem_ready) begin
                        ir       <= imem_data;
                        pc       <= pc_inc(pc);
                        imem_req <= 1'b0;
                        state    <= ST_DECODE;
                    end else begin
                        imem_req <= 1'b1;
                    end
                end
                ST_DECODE: begin
                    if (dec.is_halt) begin
                        halted <= 1'b1;
                        state  <= ST_HALT;
                    end else if (dec.needs_operand) begin
                        imem_req <= 1'b1;
                        state    <= ST_FETCH_OP;
                    end else begin
                        rf_we   <= dec.writes_rf;
                        illegal <= dec.is_illegal;
                        state   <= ST_EXECUTE;
                    end
                end
                ST_FETCH_OP: begin
                    if (imem_req && imem_ready) begin
                        opr      <= imem_data;
                        pc       <= pc_inc(pc);
                        imem_req <= 1'b0;
                        rf_we    <= dec.writes_rf;
                        state    <= ST_EXECUTE;
                    end else begin
                        imem_req <= 1'b1;
                    end
                end
                ST_EXECUTE: begin
                    rf_we   <= 1'b0;
                    illegal <= 1'b0;
                    if (dec.updates_zero) begin
                        zero_flag <= (alu_result == 8'h00);
                    end
                    if (dec.is_jump || (dec.is_jz && zero_flag)) begin
                        pc <= opr;
                    end
                    imem_req <= 1'b1;
                    state    <= ST_FETCH;
                end
                ST_HALT: begin
                    imem_req <= 1'b0;
                    rf_we    <= 1'b0;
                    illegal  <= 1'b0;
                end
                default: begin
                    imem_req <= 1'b0;
                    rf_we    <= 1'b0;
                    illegal  <= 1'b0;
                    state    <= ST_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Scoreboard bench for cpu_control_fsm: expected fetch/write/illegal events
// are queued by the stimulus and popped by an independent monitor.
module tb_cpu_control_fsm;

    logic       clk;
    logic       reset;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ready;
    logic [7:0] imem_data;
    logic [1:0] rf_src1;
    logic [1:0] rf_src2;
    logic [1:0] rf_dest;
    logic       rf_we;
    logic [7:0] rf_write_data;
    logic [2:0] alu_op;
    logic [7:0] alu_result;
    logic [7:0] pc;
    logic       zero_flag;
    logic       halted;
    logic       illegal;

    logic       ready_en;
    logic [7:0] mem [0:255];

    typedef struct packed {
        logic [1:0] kind;   // 0 fetch accepted, 1 register write, 2 illegal pulse
        logic [7:0] a;
        logic [7:0] b;
    } ev_t;

    ev_t exp_q[$];
    int  n_chk;
    int  n_pass;

    cpu_control_fsm #(.RESET_PC(8'h00)) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_data     (imem_data),
        .rf_src1       (rf_src1),
        .rf_src2       (rf_src2),
        .rf_dest       (rf_dest),
        .rf_we         (rf_we),
        .rf_write_data (rf_write_data),
        .alu_op        (alu_op),
        .alu_result    (alu_result),
        .pc            (pc),
        .zero_flag     (zero_flag),
        .halted        (halted),
        .illegal       (illegal)
    );

    assign imem_ready = ready_en;
    assign imem_data  = mem[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic sb_check(input ev_t got);
        ev_t e;
        n_chk++;
        if (exp_q.size() == 0) begin
            $display("FAIL sb_unexpected: got kind=%0d a=%02h b=%02h expected none",
                     got.kind, got.a, got.b);
        end else begin
            e = exp_q.pop_front();
            if (e === got) n_pass++;
            else $display("FAIL sb_event: got kind=%0d a=%02h b=%02h expected kind=%0d a=%02h b=%02h",
                          got.kind, got.a, got.b, e.kind, e.a, e.b);
        end
    endtask

    task automatic push_f(input logic [7:0] a);
        exp_q.push_back({2'd0, a, 8'h00});
    endtask

    task automatic push_w(input logic [1:0] d, input logic [7:0] v);
        exp_q.push_back({2'd1, 6'b0, d, v});
    endtask

    task automatic push_i();
        exp_q.push_back({2'd2, 8'h00, 8'h00});
    endtask

    // Wait (bounded) until the DUT requests the given address.
    task automatic wait_fetch(input logic [7:0] a, input string nm);
        int n;
        n = 0;
        while (!(imem_req && imem_addr == a) && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk(nm, (n < 60), 1);
    endtask

    task automatic wait_halt(input string nm);
        int n;
        n = 0;
        while (!halted && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk(nm, halted, 1);
    endtask

    // Monitor: observe DUT events just after the falling edge, when inputs
    // for the next rising edge have settled.
    always begin
        @(negedge clk);
        #1;
        if (!reset) begin
            if (imem_req && imem_ready) sb_check({2'd0, imem_addr, 8'h00});
            if (rf_we)                  sb_check({2'd1, 6'b0, rf_dest, rf_write_data});
            if (illegal)                sb_check({2'd2, 8'h00, 8'h00});
        end
    end

    initial begin
        int n;
        int req_seen;
        n_chk      = 0;
        n_pass     = 0;
        reset      = 1'b1;
        ready_en   = 1'b1;
        alu_result = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'h75; mem[8'h01] = 8'h3C;   // LDI r1,0x3C
        mem[8'h02] = 8'h16;                        // ADD r1,r2 (result 0)
        mem[8'h03] = 8'h90; mem[8'h04] = 8'h40;   // JZ 0x40 (taken)
        mem[8'h40] = 8'h16;                        // ADD r1,r2 (result 5)
        mem[8'h41] = 8'h90; mem[8'h42] = 8'h80;   // JZ 0x80 (not taken)
        mem[8'h43] = 8'h69;                        // MOV r2,r1
        mem[8'h44] = 8'h00;                        // NOP
        mem[8'h45] = 8'hB0;                        // illegal
        mem[8'h46] = 8'h80; mem[8'h47] = 8'hFF;   // JMP 0xFF
        mem[8'hFF] = 8'h80;                        // JMP, operand wraps to 0x00 -> 0x75
        mem[8'h75] = 8'hF0;                        // HLT

        repeat (2) @(negedge clk);
        chk("rst_imem_req", imem_req, 0);
        chk("rst_imem_addr", imem_addr, 8'h00);
        chk("rst_pc", pc, 8'h00);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_zero", zero_flag, 0);
        chk("rst_halted", halted, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_wdata", rf_write_data, 8'h00);

        push_f(8'h00); push_f(8'h01); push_w(2'd1, 8'h3C);
        push_f(8'h02); push_w(2'd1, 8'h00);
        push_f(8'h03); push_f(8'h04);
        push_f(8'h40); push_w(2'd1, 8'h05);
        push_f(8'h41); push_f(8'h42);
        push_f(8'h43); push_w(2'd2, 8'hA5);
        push_f(8'h44); push_f(8'h45); push_i();
        push_f(8'h46); push_f(8'h47);
        push_f(8'hFF); push_f(8'h00);
        push_f(8'h75);

        reset = 1'b0;
        @(negedge clk);
        chk("req_rise", imem_req, 1);

        wait_fetch(8'h02, "reach_02");
        chk("pc_after_ldi", pc, 8'h02);
        chk("zero_before_add", zero_flag, 0);
        wait_fetch(8'h03, "reach_03");
        chk("zero_set", zero_flag, 1);
        wait_fetch(8'h40, "jz_taken");
        alu_result = 8'h05;
        wait_fetch(8'h41, "reach_41");
        chk("zero_clear", zero_flag, 0);

        ready_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_req", imem_req, 1);
            chk("stall_addr", {imem_addr, pc}, {8'h41, 8'h41});
        end
        ready_en = 1'b1;

        wait_fetch(8'h43, "jz_fallthrough");
        alu_result = 8'hA5;
        wait_fetch(8'h44, "reach_44");
        chk("mov_decode", {alu_op, 2'b0, rf_src1, rf_src2}, {3'd5, 2'b0, 2'd2, 2'd1});
        wait_fetch(8'h46, "reach_46");
        chk("zero_kept_mov", zero_flag, 0);
        wait_fetch(8'hFF, "jmp_ff");
        wait_fetch(8'h00, "wrap_fetch");
        wait_fetch(8'h75, "jmp_opr");
        wait_halt("halt_reached");
        req_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (imem_req || rf_we) req_seen++;
        end
        chk("halt_quiet", req_seen, 0);
        chk("halt_stays", halted, 1);
        chk("queue_empty_1", exp_q.size(), 0);

        // Reset in the middle of an ADD's EXECUTE cycle.
        mem[8'h00] = 8'h16;
        mem[8'h01] = 8'hF0;
        alu_result = 8'h00;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("async_halt_clr", {halted, imem_req}, 0);
        @(negedge clk);
        push_f(8'h00);
        reset = 1'b0;
        n = 0;
        while (!rf_we && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ex_reached", rf_we, 1);
        reset = 1'b1;
        #1;
        chk("abort_we", rf_we, 0);
        chk("abort_pc", pc, 8'h00);
        chk("abort_req", imem_req, 0);
        @(negedge clk);
        chk("abort_zero", zero_flag, 0);
        chk("abort_state", {rf_we, halted}, 0);
        push_f(8'h00); push_w(2'd1, 8'h00); push_f(8'h01);
        reset = 1'b0;
        wait_halt("restart_halt");
        chk("restart_zero", zero_flag, 1);
        chk("queue_empty_2", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
